// File: rtl/skinny_sbox_ghpc_pipe.sv
// Masked SKINNY-64 S-box: order-D sharing, LANES nibbles per beat, five register
// stages built around one-cycle AND gadgets, valid/ready with whole-pipeline stall.

module skinny_ghpc_and #(
   parameter int NSH = 2,
   parameter int R   = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [NSH-1:0] a,
   input  logic [NSH-1:0] b,
   input  logic [R-1:0]   fresh,
   output logic [NSH-1:0] z
);
   logic [NSH-1:0][NSH-1:0] term_d, term_q;

   function automatic int pidx(input int i, input int j);
      return i * NSH - i * (i + 1) / 2 + (j - i - 1);
   endfunction

   // Cross products share one fresh bit with their mirror term and are registered
   // before compression, so glitches never combine unblinded shares.
   for (genvar i = 0; i < NSH; i++) begin : g_i
      for (genvar j = 0; j < NSH; j++) begin : g_j
         if (i == j) begin : g_dom
            assign term_d[i][j] = a[i] & b[j];
         end else if (i < j) begin : g_up
            assign term_d[i][j] = (a[i] & b[j]) ^ fresh[pidx(i, j)];
         end else begin : g_lo
            assign term_d[i][j] = (a[i] & b[j]) ^ fresh[pidx(j, i)];
         end
      end
   end

   always_ff @(posedge clk)
      if (!rst_n)  term_q <= '0;
      else if (en) term_q <= term_d;

   always_comb begin
      z = '0;
      for (int i = 0; i < NSH; i++)
         for (int j = 0; j < NSH; j++)
            z[i] = z[i] ^ term_q[i][j];
   end
endmodule

module skinny_sbox_ghpc_lane #(
   parameter int NSH = 2,
   parameter int R   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [3:0][NSH-1:0]  x,
   input  logic [4*R-1:0]       fresh,
   output logic [3:0][NSH-1:0]  y
);
   // (a,b,c,d) = (x3,x2,x1,x0); y = (d', a', b', c') with
   // d' = d^(~a&~b), a' = a^(~b&~c), b' = b^(~c&~d'), c' = c^(~d'&~a').
   localparam logic [NSH-1:0] INV = NSH'(1);

   logic [NSH-1:0] s1_a, s1_b, s1_c, s1_d, s1_na, s1_nb, s1_nc;
   logic [NSH-1:0] s2_a, s2_b, s2_c, s2_d, t1, t3;
   logic [NSH-1:0] s3_b, s3_c, s3_dp, s3_ap, s3_nc, s3_ndp, s3_nap;
   logic [NSH-1:0] s4_b, s4_c, s4_dp, s4_ap, t2, t4;

   always_ff @(posedge clk)
      if (!rst_n) begin
         s1_a <= '0; s1_b <= '0; s1_c <= '0; s1_d <= '0;
         s1_na <= '0; s1_nb <= '0; s1_nc <= '0;
         s2_a <= '0; s2_b <= '0; s2_c <= '0; s2_d <= '0;
         s3_b <= '0; s3_c <= '0; s3_dp <= '0; s3_ap <= '0;
         s3_nc <= '0; s3_ndp <= '0; s3_nap <= '0;
         s4_b <= '0; s4_c <= '0; s4_dp <= '0; s4_ap <= '0;
         y <= '0;
      end else if (en) begin
         s1_a  <= x[3];       s1_b  <= x[2];       s1_c  <= x[1];       s1_d <= x[0];
         s1_na <= x[3] ^ INV; s1_nb <= x[2] ^ INV; s1_nc <= x[1] ^ INV;
         s2_a  <= s1_a;       s2_b  <= s1_b;       s2_c  <= s1_c;       s2_d <= s1_d;
         s3_b   <= s2_b;
         s3_c   <= s2_c;
         s3_dp  <= s2_d ^ t1;
         s3_ap  <= s2_a ^ t3;
         s3_nc  <= s2_c ^ INV;
         s3_ndp <= s2_d ^ t1 ^ INV;
         s3_nap <= s2_a ^ t3 ^ INV;
         s4_b  <= s3_b;  s4_c  <= s3_c;  s4_dp <= s3_dp;  s4_ap <= s3_ap;
         y[3] <= s4_dp;
         y[2] <= s4_ap;
         y[1] <= s4_b ^ t2;
         y[0] <= s4_c ^ t4;
      end

   skinny_ghpc_and #(.NSH(NSH), .R(R)) u_and1 (
      .clk(clk), .rst_n(rst_n), .en(en), .a(s1_na), .b(s1_nb), .fresh(fresh[0 +: R]), .z(t1));
   skinny_ghpc_and #(.NSH(NSH), .R(R)) u_and3 (
      .clk(clk), .rst_n(rst_n), .en(en), .a(s1_nb), .b(s1_nc), .fresh(fresh[R +: R]), .z(t3));
   skinny_ghpc_and #(.NSH(NSH), .R(R)) u_and2 (
      .clk(clk), .rst_n(rst_n), .en(en), .a(s3_nc), .b(s3_ndp), .fresh(fresh[2*R +: R]), .z(t2));
   skinny_ghpc_and #(.NSH(NSH), .R(R)) u_and4 (
      .clk(clk), .rst_n(rst_n), .en(en), .a(s3_ndp), .b(s3_nap), .fresh(fresh[3*R +: R]), .z(t4));
endmodule

module skinny_sbox_ghpc_pipe #(
   parameter  int D     = 1,
   parameter  int LANES = 1,
   localparam int NSH   = D + 1,
   localparam int R     = D * (D + 1) / 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NSH*LANES*4-1:0]   x_shares,
   input  logic [LANES*4*R-1:0]     fresh,
   output logic                     fresh_req,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NSH*LANES*4-1:0]   y_shares
);
   logic       advance, accept;
   logic [5:1] vld_pipe;
   logic [LANES-1:0][3:0][NSH-1:0] x_lane, y_lane;

   assign advance   = !vld_pipe[5] | out_ready;
   assign in_ready  = advance & rst_n;
   assign fresh_req = advance & rst_n;
   assign accept    = in_valid & in_ready;
   assign out_valid = vld_pipe[5];

   always_ff @(posedge clk)
      if (!rst_n)       vld_pipe <= '0;
      else if (advance) vld_pipe <= {vld_pipe[4:1], accept};

   // Regroup the share-major bus into per-lane, per-bit share vectors.
   always_comb begin
      x_lane   = '0;
      y_shares = '0;
      for (int s = 0; s < NSH; s++)
         for (int l = 0; l < LANES; l++)
            for (int b = 0; b < 4; b++) begin
               x_lane[l][b][s]                = x_shares[(s*LANES+l)*4+b];
               y_shares[(s*LANES+l)*4+b]      = y_lane[l][b][s];
            end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      skinny_sbox_ghpc_lane #(.NSH(NSH), .R(R)) u_lane (
         .clk(clk), .rst_n(rst_n), .en(advance),
         .x(x_lane[l]), .fresh(fresh[l*4*R +: 4*R]), .y(y_lane[l]));
   end
endmodule

// File: tb/tb_skinny_sbox_ghpc_pipe.sv
// Scoreboard bench: D=1/LANES=1 instance for protocol and exhaustive checks,
// D=2/LANES=16 instance for full SubCells on 64-bit states.

module tb_skinny_sbox_ghpc_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   localparam logic [3:0] SBOX [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                        4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

   // instance A
   logic       rst_n, in_valid, out_ready, in_ready, fresh_req, out_valid;
   logic [7:0] x_shares, y_shares;
   logic [3:0] fresh;

   // instance B
   logic         rst2_n, in_valid2, in_ready2, fresh_req2, out_valid2;
   logic         out_ready2;
   logic [191:0] x2, y2, fresh2;

   skinny_sbox_ghpc_pipe #(.D(1), .LANES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x_shares(x_shares), .fresh(fresh), .fresh_req(fresh_req),
      .out_valid(out_valid), .out_ready(out_ready), .y_shares(y_shares));

   skinny_sbox_ghpc_pipe #(.D(2), .LANES(16)) dut_b (
      .clk(clk), .rst_n(rst2_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .x_shares(x2), .fresh(fresh2), .fresh_req(fresh_req2),
      .out_valid(out_valid2), .out_ready(out_ready2), .y_shares(y2));

   typedef struct {
      logic [3:0] val;
      int         adv;
   } sb_t;

   sb_t         q_a[$];
   logic [63:0] q_b[$];
   logic [7:0]  ylog[$];
   logic        log_en = 1'b0;
   int          adv_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] sub64(input logic [63:0] s);
      logic [63:0] r;
      r = '0;
      for (int l = 0; l < 16; l++) r[l*4 +: 4] = SBOX[s[l*4 +: 4]];
      return r;
   endfunction

   // fresh randomness changes every cycle
   always @(posedge clk) begin
      #1;
      fresh  = 4'($urandom);
      fresh2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   end

   // model of advancing edges for instance A (stall edges do not count)
   always @(posedge clk)
      if (rst_n && (!out_valid || out_ready)) adv_cnt <= adv_cnt + 1;

   always @(negedge clk) begin : mon_a
      sb_t e;
      if (rst_n && out_valid && out_ready) begin
         if (q_a.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_beat_a: got y=%h expected no beat", y_shares);
         end else begin
            e = q_a.pop_front();
            check("sbox_a", 64'(y_shares[3:0] ^ y_shares[7:4]), 64'(e.val));
            check("latency_a", 64'(adv_cnt - e.adv), 64'(5));
            if (log_en) ylog.push_back(y_shares);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [63:0] e;
      if (rst2_n && out_valid2 && out_ready2) begin
         if (q_b.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_beat_b: got y=%h expected no beat", y2[63:0] ^ y2[127:64] ^ y2[191:128]);
         end else begin
            e = q_b.pop_front();
            check("subcells_b", y2[63:0] ^ y2[127:64] ^ y2[191:128], e);
         end
      end
   end

   task automatic send_a(input logic [3:0] x);
      logic [3:0] m;
      bit         done;
      sb_t        e;
      m = 4'($urandom);
      x_shares = {x ^ m, m};
      in_valid = 1'b1;
      done = 1'b0;
      for (int t = 0; t < 30 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.val = SBOX[x];
            e.adv = adv_cnt;
            q_a.push_back(e);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!done) check("accept_timeout_a", 64'(0), 64'(1));
      in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [63:0] x, input logic [63:0] exp);
      logic [63:0] m1, m2;
      bit          done;
      m1 = {$urandom, $urandom};
      m2 = {$urandom, $urandom};
      x2 = {x ^ m1 ^ m2, m2, m1};
      in_valid2 = 1'b1;
      done = 1'b0;
      for (int t = 0; t < 30 && !done; t++) begin
         @(negedge clk);
         if (in_ready2) begin
            q_b.push_back(exp);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!done) check("accept_timeout_b", 64'(0), 64'(1));
      in_valid2 = 1'b0;
   endtask

   task automatic drain;
      int t;
      t = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && t < 60) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 60) check("drain_timeout", 64'(q_a.size() + q_b.size()), 64'(0));
      repeat (3) begin @(posedge clk); #1; end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] ycap;
      logic [63:0] r;
      int same0, same1;
      rst_n = 1'b0; rst2_n = 1'b0;
      in_valid = 1'b0; in_valid2 = 1'b0;
      out_ready = 1'b1; out_ready2 = 1'b1;
      x_shares = '0; x2 = '0;
      fresh = '0; fresh2 = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_fresh_req", 64'(fresh_req), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_y_shares", 64'(y_shares), 64'(0));
      check("rst_out_valid_b", 64'(out_valid2), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1; rst2_n = 1'b1;
      @(posedge clk); #1;

      // exhaustive stream, back to back
      for (int x = 0; x < 16; x++) send_a(4'(x));
      drain();

      // backpressure: 5 in flight, 3 stalled cycles
      send_a(4'h5); send_a(4'hA); send_a(4'h3); send_a(4'hE); send_a(4'h0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x_shares  = 8'h5A;
      @(negedge clk);
      ycap = y_shares;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'(0));
         check("stall_fresh_req", 64'(fresh_req), 64'(0));
         check("stall_y_stable", 64'(y_shares), 64'(ycap));
         check("stall_out_valid", 64'(out_valid), 64'(1));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // bubbles 1,0,0,1
      send_a(4'h7);
      @(posedge clk); #1;
      @(posedge clk); #1;
      send_a(4'hC);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bubble_pattern", 64'(out_valid), 64'((i == 0 || i == 3) ? 1 : 0));
      end
      drain();

      // reset with 3 beats in flight
      send_a(4'h1); send_a(4'h2); send_a(4'h4);
      rst_n = 1'b0;
      q_a.delete();
      @(negedge clk);
      check("midrst_in_ready", 64'(in_ready), 64'(0));
      check("midrst_fresh_req", 64'(fresh_req), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_y_zero", 64'(y_shares), 64'(0));
      repeat (10) begin @(posedge clk); #1; end
      send_a(4'h9); send_a(4'hB);
      drain();

      // randomness independence: fixed input, varying masks and fresh bits
      ylog.delete();
      log_en = 1'b1;
      for (int i = 0; i < 8; i++) send_a(4'h6);
      drain();
      log_en = 1'b0;
      check("rand_log_count", 64'(ylog.size()), 64'(8));
      same0 = 1; same1 = 1;
      foreach (ylog[i]) begin
         if (ylog[i][3:0] != ylog[0][3:0]) same0 = 0;
         if (ylog[i][7:4] != ylog[0][7:4]) same1 = 0;
      end
      check("share0_varies", 64'(same0), 64'(0));
      check("share1_varies", 64'(same1), 64'(0));

      // D=2, 16 lanes
      send_b(64'h0123456789ABCDEF, 64'hC6901A2B385D4E7F);
      send_b(64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC);
      send_b(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      send_b(64'h3333333333333333, 64'h0000000000000000);
      for (int i = 0; i < 3; i++) begin
         r = {$urandom, $urandom};
         send_b(r, sub64(r));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
